tt_um_nlp52_switch_debouncer: RTL and testbench



---
 rtl/tt_um_nlp52_switch_debouncer.sv | 235 +++++++++++++++++++++++
 tb/tb_tt_um_nlp52_switch_debouncer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tt_um_nlp52_switch_debouncer.sv
// -----------------------------------------------------------------------------
// tt_um_nlp52_switch_debouncer
//
// Purpose:
//   Input conditioning for the three voter switches that feed the
//   majority-of-three detector. Each raw switch is synchronised through two
//   flops. A per-channel four-state FSM then debounces it. The debounced
//   levels, one-cycle rising-edge pulses, an any-change pulse and an
//   all-settled flag are presented on the TinyTapeout user pinout.
//
// Ports:
//   clk      in   1  system clock
//   rst_n    in   1  asynchronous active-low reset
//   ena      in   1  design enable; while low, pending counts are abandoned
//                    and pulses are suppressed
//   ui_in    in   8  [2:0] raw switch inputs, [7:3] ignored
//   uo_out   out  8  [2:0] debounced levels
//                    [5:3] rising-edge pulse per channel
//                    [6]   any-change pulse
//                    [7]   all channels in a stable state
//   uio_in   in   8  ignored
//   uio_out  out  8  tied low
//   uio_oe   out  8  tied low (all bidirectionals are inputs)
//
// Debug:
//   dbg_state is a packed copy of the three channel FSM states. Channel i
//   occupies bits [2*i+1:2*i]. Checkers can bind to it hierarchically.
//
// Timing:
//   A clean step reaches uo_out[i] DEBOUNCE_CYCLES+3 edges after the first
//   edge that samples it: 2 sync, DEBOUNCE_CYCLES count, 1 commit.
// -----------------------------------------------------------------------------
module tt_um_nlp52_switch_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int NUM_CH = 3;
  localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } db_state_e;

  // Two-flop synchroniser per channel. It runs regardless of ena.
  logic [NUM_CH-1:0] sync1_q;
  logic [NUM_CH-1:0] sync2_q;

  // Per-channel debounce state.
  db_state_e         state_q [NUM_CH];
  db_state_e         state_d [NUM_CH];
  logic [CNT_W-1:0]  cnt_q   [NUM_CH];
  logic [CNT_W-1:0]  cnt_d   [NUM_CH];
  logic [NUM_CH-1:0] db_q;
  logic [NUM_CH-1:0] db_d;

  // db_prev_q lags db_q by one cycle. The pulses fire in the cycle after
  // db changes, not in the same cycle.
  logic [NUM_CH-1:0] db_prev_q;
  logic [NUM_CH-1:0] rise_q;
  logic [NUM_CH-1:0] rise_d;
  logic              chg_q;
  logic              chg_d;

  logic              all_stable;
  logic [5:0]        dbg_state;

  // Unused pins are folded into one signal so they are visibly consumed.
  logic              unused_inputs;
  assign unused_inputs = ^{ui_in[7:3], uio_in};

  // ---------------------------------------------------------------------------
  // Synchroniser
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= ui_in[NUM_CH-1:0];
      sync2_q <= sync1_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce FSM state registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= STABLE_LO;
        cnt_q[i]   <= '0;
      end
      db_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      db_q <= db_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce FSM next-state logic
  // The counter is only incremented while it is below CNT_MAX. Reaching
  // CNT_MAX always leaves the WAIT state, so the counter cannot wrap.
  // ---------------------------------------------------------------------------
  always_comb begin
    db_d = db_q;
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];

      if (!ena) begin
        // Abandon any pending change. Stable states and db hold.
        unique case (state_q[i])
          WAIT_HI: begin
            state_d[i] = STABLE_LO;
            cnt_d[i]   = '0;
          end
          WAIT_LO: begin
            state_d[i] = STABLE_HI;
            cnt_d[i]   = '0;
          end
          default: ;
        endcase
      end else begin
        unique case (state_q[i])
          STABLE_LO: begin
            if (sync2_q[i]) begin
              state_d[i] = WAIT_HI;
              cnt_d[i]   = CNT_ONE;
            end
          end
          WAIT_HI: begin
            if (!sync2_q[i]) begin
              // Bounce: the input fell back before the hold time elapsed.
              state_d[i] = STABLE_LO;
              cnt_d[i]   = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
              state_d[i] = STABLE_HI;
              cnt_d[i]   = '0;
              db_d[i]    = 1'b1;
            end else begin
              cnt_d[i]   = cnt_q[i] + CNT_ONE;
            end
          end
          STABLE_HI: begin
            if (!sync2_q[i]) begin
              state_d[i] = WAIT_LO;
              cnt_d[i]   = CNT_ONE;
            end
          end
          WAIT_LO: begin
            if (sync2_q[i]) begin
              state_d[i] = STABLE_HI;
              cnt_d[i]   = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
              state_d[i] = STABLE_LO;
              cnt_d[i]   = '0;
              db_d[i]    = 1'b0;
            end else begin
              cnt_d[i]   = cnt_q[i] + CNT_ONE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Edge pulses
  // Both pulses are derived from the committed level and its one-cycle-old
  // copy. Simultaneous commits on several channels therefore merge into a
  // single change pulse.
  // ---------------------------------------------------------------------------
  always_comb begin
    rise_d = '0;
    chg_d  = 1'b0;
    if (ena) begin
      rise_d = db_q & ~db_prev_q;
      chg_d  = |(db_q ^ db_prev_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_prev_q <= '0;
      rise_q    <= '0;
      chg_q     <= 1'b0;
    end else begin
      db_prev_q <= db_q;
      rise_q    <= rise_d;
      chg_q     <= chg_d;
    end
  end

  // ---------------------------------------------------------------------------
  // All-stable flag and debug state
  // ---------------------------------------------------------------------------
  always_comb begin
    all_stable = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if ((state_q[i] == WAIT_HI) || (state_q[i] == WAIT_LO)) begin
        all_stable = 1'b0;
      end
    end
  end

  assign dbg_state = {state_q[2], state_q[1], state_q[0]};

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign uo_out  = {all_stable, chg_q, rise_q, db_q};
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_nlp52_switch_debouncer.sv
// -----------------------------------------------------------------------------
// Bench for tt_um_nlp52_switch_debouncer with DEBOUNCE_CYCLES = 4.
//
// Reference model:
//   A channel's level flips once the synchronised input has disagreed with
//   it, with ena high, on DEB+1 consecutive edges. The synchronised input is
//   the raw input delayed by two edges. The channel counts as settled
//   whenever that run length is zero. Pulses echo the previous edge's level
//   changes while ena is high.
// -----------------------------------------------------------------------------
module tb_tt_um_nlp52_switch_debouncer;

  localparam int DEB = 4;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  always #5 clk = ~clk;

  tt_um_nlp52_switch_debouncer #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  int n_total = 0;
  int n_bad   = 0;
  int n_print = 0;

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  bit [2:0] m_s1, m_s2;          // raw input seen one and two edges ago
  bit [2:0] m_db;                // committed levels
  bit [2:0] m_rose, m_fell;      // level changes made at the last edge
  bit [2:0] m_rise;
  bit       m_chg;
  int       m_run [3];           // consecutive qualifying disagreement edges

  always @(posedge clk or negedge rst_n) begin : model
    bit [2:0] db_n;
    bit [2:0] rose_n;
    bit [2:0] fell_n;
    int       run_n [3];
    if (!rst_n) begin
      m_s1   <= '0;
      m_s2   <= '0;
      m_db   <= '0;
      m_rose <= '0;
      m_fell <= '0;
      m_rise <= '0;
      m_chg  <= 1'b0;
      for (int i = 0; i < 3; i++) m_run[i] <= 0;
    end else begin
      db_n   = m_db;
      rose_n = '0;
      fell_n = '0;
      for (int i = 0; i < 3; i++) begin
        run_n[i] = (ena && (m_s2[i] != m_db[i])) ? m_run[i] + 1 : 0;
        if (run_n[i] == DEB + 1) begin
          db_n[i]  = ~m_db[i];
          run_n[i] = 0;
          if (db_n[i]) rose_n[i] = 1'b1;
          else         fell_n[i] = 1'b1;
        end
      end
      m_rise <= ena ? m_rose : 3'b000;
      m_chg  <= ena && ((m_rose | m_fell) != 3'b000);
      m_rose <= rose_n;
      m_fell <= fell_n;
      m_db   <= db_n;
      for (int i = 0; i < 3; i++) m_run[i] <= run_n[i];
      m_s2   <= m_s1;
      m_s1   <= ui_in[2:0];
    end
  end

  function automatic logic [7:0] model_out();
    bit settled;
    settled = (m_run[0] == 0) && (m_run[1] == 0) && (m_run[2] == 0);
    return {settled, m_chg, m_rise, m_db};
  endfunction

  // ---------------------------------------------------------------------------
  // Scoreboard: every cycle, compare against the model on the falling edge
  // ---------------------------------------------------------------------------
  logic [7:0] exp_q[$];
  int         cyc = 0;

  always @(negedge clk) begin
    logic [7:0] exp_v;
    cyc++;
    exp_q.push_back(model_out());
    exp_v = exp_q.pop_front();
    n_total++;
    if (uo_out !== exp_v) begin
      n_bad++;
      if (n_print < 40) begin
        n_print++;
        $display("FAIL model_cmp cyc=%0d uo_out got=%h exp=%h", cyc, uo_out, exp_v);
      end
    end
    n_total++;
    if ({uio_out, uio_oe} !== 16'h0000) begin
      n_bad++;
      if (n_print < 40) begin
        n_print++;
        $display("FAIL uio_tie cyc=%0d got=%h exp=0000", cyc, {uio_out, uio_oe});
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_lit(input string name, input logic [7:0] exp_v);
    n_total++;
    if (uo_out !== exp_v) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", name, uo_out, exp_v);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    tick(1);
    check_lit("reset_hold", 8'h80);
    tick(2);
    rst_n = 1'b1;
    tick(10);
    check_lit("idle", 8'h80);

    // Clean press on channel 0
    ui_in = 8'h01;
    tick(2);  check_lit("press_sync", 8'h80);
    tick(1);  check_lit("press_wait_start", 8'h00);
    tick(3);  check_lit("press_wait_end", 8'h00);
    tick(1);  check_lit("press_commit", 8'h81);
    tick(1);  check_lit("press_pulse", 8'hC9);
    tick(1);  check_lit("press_after", 8'h81);

    // Bounce on channel 1: never reaches the hold time
    ui_in = 8'h03; tick(3);
    ui_in = 8'h01; tick(3);
    ui_in = 8'h03; tick(3);
    ui_in = 8'h01; tick(10);
    check_lit("bounce_rejected", 8'h81);

    // Raise then release channel 2
    ui_in = 8'h05; tick(10);
    check_lit("ch2_high", 8'h85);
    ui_in = 8'h01;
    tick(6);  check_lit("release_wait", 8'h05);
    tick(1);  check_lit("release_commit", 8'h81);
    tick(1);  check_lit("release_pulse", 8'hC1);
    tick(1);  check_lit("release_after", 8'h81);

    // Simultaneous rise on channels 0 and 1
    ui_in = 8'h00; tick(10);
    check_lit("all_low", 8'h80);
    ui_in = 8'h03;
    tick(7);  check_lit("simul_commit", 8'h83);
    tick(1);  check_lit("simul_pulse", 8'hDB);
    tick(1);  check_lit("simul_after", 8'h83);

    // Enable gating
    ui_in = 8'h00; tick(10);
    check_lit("gate_idle", 8'h80);
    ui_in = 8'h01;
    tick(5);  check_lit("gate_counting", 8'h00);
    ena = 1'b0;
    tick(1);  check_lit("gate_abandon", 8'h80);
    tick(5);  check_lit("gate_held", 8'h80);
    ena = 1'b1;
    tick(1);  check_lit("gate_restart", 8'h00);
    tick(3);  check_lit("gate_recount", 8'h00);
    tick(1);  check_lit("gate_commit", 8'h81);
    tick(1);  check_lit("gate_pulse", 8'hC9);

    // Asynchronous reset mid-cycle with all switches high
    ui_in = 8'h07; tick(2);
    #2 rst_n = 1'b0;
    #1 check_lit("async_reset", 8'h80);
    tick(2);  check_lit("reset_low", 8'h80);
    rst_n = 1'b1;
    tick(6);  check_lit("rst_wait", 8'h00);
    tick(1);  check_lit("rst_commit", 8'h87);
    tick(1);  check_lit("rst_pulse", 8'hFF);
    tick(1);  check_lit("rst_after", 8'h87);

    // Randomised phase: independent per-channel toggling and enable drops
    for (int k = 0; k < 2000; k++) begin
      logic [7:0] v;
      v = ui_in;
      for (int i = 0; i < 3; i++) begin
        if ($urandom_range(0, 5) == 0) v[i] = ~v[i];
      end
      v[7:3] = 5'($urandom_range(0, 31));
      ui_in  = v;
      uio_in = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 19) == 0) ena = ~ena;
      if (k == 1000) begin
        #2 rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
      end else begin
        tick(1);
      end
    end

    ena   = 1'b1;
    ui_in = 8'h00;
    tick(12);
    check_lit("final_idle", 8'h80);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
